dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arb_pkg.sv | 14 +
 rtl/arb_pick2.sv | 24 ++
 rtl/dmem_arbiter.sv | 161 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the two-port data-memory arbiter: FSM state
// encoding and the port-index constants used by the arbiter and its picker.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_RDWAIT = 2'd2
  } arb_state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_LDR = 1'b1;

endpackage

// File: rtl/arb_pick2.sv
// Two-way grant picker. Port 0 wins by default; 'hist' hands a conflict to
// port 1 (starvation limit reached, or round-robin says port 1 is next).
module arb_pick2
  import dmem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic hist,
  output logic winner
);

  // Resolve the winner from the two requests and the history bit
  always_comb begin
    winner = PORT_CPU;
    if (req0 && req1) begin
      winner = hist ? PORT_LDR : PORT_CPU;
    end else if (req1) begin
      winner = PORT_LDR;
    end else begin
      winner = PORT_CPU;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter (port 0 = CPU load/store, port 1 = loader).
// One transaction at a time: grant in IDLE, command in ISSUE, read return in
// RDWAIT. Define DMEM_ARB_RR_EN for round-robin arbitration; the default build
// uses fixed priority with a starvation limit for port 1.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
)
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_req,
  input  logic [3:0]        p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic [3:0]        p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic [ADDR_W-1:0] m_addr,
  output logic [3:0]        m_we,
  output logic [DATA_W-1:0] m_wdata,
  output logic              m_rd,
  input  logic [DATA_W-1:0] m_rdata
);

  arb_state_t        state_r;
  logic              win_r;
  logic [DATA_W-1:0] rdata0_r;
  logic [DATA_W-1:0] rdata1_r;
  logic              hist_s;
  logic              pick_s;
  logic              take_s;

  // A request is accepted only while idle; the grant is the accept strobe
  assign take_s = (state_r == ST_IDLE) && (p0_req || p1_req);
  assign p0_gnt = take_s && (pick_s == PORT_CPU);
  assign p1_gnt = take_s && (pick_s == PORT_LDR);

  // Read data appears straight from memory in the rvalid cycle, then holds
  assign p0_rdata = p0_rvalid ? m_rdata : rdata0_r;
  assign p1_rdata = p1_rvalid ? m_rdata : rdata1_r;

  arb_pick2 u_pick (
    .req0   (p0_req),
    .req1   (p1_req),
    .hist   (hist_s),
    .winner (pick_s)
  );

`ifdef DMEM_ARB_RR_EN
  // rr_last holds the port that wins the next conflict (the one not granted
  // last); resetting it to port 0 keeps the first post-reset grant on port 0.
  logic rr_last_r;
  assign hist_s = rr_last_r;

  // Hand the next conflict to the port that was just passed over
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last_r <= PORT_CPU;
    end else if (take_s) begin
      rr_last_r <= ~pick_s;
    end else begin
      rr_last_r <= rr_last_r;
    end
  end
`else
  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  logic [CNT_W-1:0] starve_cnt_r;
  assign hist_s = (starve_cnt_r == CNT_W'(STARVE_MAX));

  // Count port-0 grants that overtake a waiting port 1, saturating at the limit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_r <= {CNT_W{1'b0}};
    end else if (!p1_req) begin
      starve_cnt_r <= {CNT_W{1'b0}};
    end else if (take_s && (pick_s == PORT_LDR)) begin
      starve_cnt_r <= {CNT_W{1'b0}};
    end else if (take_s && (starve_cnt_r != CNT_W'(STARVE_MAX))) begin
      starve_cnt_r <= starve_cnt_r + CNT_W'(1);
    end else begin
      starve_cnt_r <= starve_cnt_r;
    end
  end
`endif

  // Transaction FSM: latch the winner's payload as the memory command, then
  // return read data; strobes default low every cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      win_r     <= PORT_CPU;
      m_addr    <= {ADDR_W{1'b0}};
      m_we      <= 4'b0000;
      m_wdata   <= {DATA_W{1'b0}};
      m_rd      <= 1'b0;
      p0_rvalid <= 1'b0;
      p1_rvalid <= 1'b0;
      rdata0_r  <= {DATA_W{1'b0}};
      rdata1_r  <= {DATA_W{1'b0}};
    end else begin
      m_we      <= 4'b0000;
      m_rd      <= 1'b0;
      p0_rvalid <= 1'b0;
      p1_rvalid <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (take_s) begin
            state_r <= ST_ISSUE;
            win_r   <= pick_s;
            if (pick_s == PORT_LDR) begin
              m_addr  <= p1_addr;
              m_we    <= p1_we;
              m_wdata <= p1_wdata;
              m_rd    <= (p1_we == 4'b0000);
            end else begin
              m_addr  <= p0_addr;
              m_we    <= p0_we;
              m_wdata <= p0_wdata;
              m_rd    <= (p0_we == 4'b0000);
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          // m_rd is high exactly while a read command is on the bus
          if (m_rd) begin
            state_r   <= ST_RDWAIT;
            p0_rvalid <= (win_r == PORT_CPU);
            p1_rvalid <= (win_r == PORT_LDR);
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_RDWAIT: begin
          state_r <= ST_IDLE;
          if (win_r == PORT_LDR) begin
            rdata1_r <= m_rdata;
          end else begin
            rdata0_r <= m_rdata;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized
// two-port traffic against a transaction-level reference model.
module tb_dmem_arbiter;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int STARVE_MAX = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              p0_req, p1_req;
  logic [3:0]        p0_we, p1_we;
  logic [ADDR_W-1:0] p0_addr, p1_addr;
  logic [DATA_W-1:0] p0_wdata, p1_wdata;
  logic              p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
  logic [DATA_W-1:0] p0_rdata, p1_rdata;
  logic [ADDR_W-1:0] m_addr;
  logic [3:0]        m_we;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W-1:0] m_rdata;
  logic              m_rd;

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .m_addr(m_addr), .m_we(m_we), .m_wdata(m_wdata), .m_rd(m_rd), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Requester state (payload held until granted)
  logic        rq_v    [2];
  logic [3:0]  rq_we   [2];
  logic [31:0] rq_addr [2];
  logic [31:0] rq_wdata[2];

  // Bench memory (driven from DUT commands) and the model's own shadow copy
  logic [31:0] mem     [16];
  logic [31:0] ref_mem [16];
  logic        mrd_pend;
  logic [3:0]  mrd_idx;

  // Reference model: expectations scheduled by cycle number
  int          cyc;
  int          busy;
  int          starve;
  logic        prefer_ldr;
  logic        e_cv   [8];
  logic [31:0] e_addr [8];
  logic [3:0]  e_we   [8];
  logic [31:0] e_wdata[8];
  logic        e_rd   [8];
  logic        e_rv0  [8];
  logic        e_rv1  [8];
  logic [31:0] e_rvd  [8];
  logic [31:0] last0, last1;
  int          dut_grants[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      e_cv[i] = 1'b0; e_addr[i] = 32'h0; e_we[i] = 4'h0; e_wdata[i] = 32'h0;
      e_rd[i] = 1'b0; e_rv0[i] = 1'b0; e_rv1[i] = 1'b0; e_rvd[i] = 32'h0;
    end
    busy = 0; starve = 0; prefer_ldr = 1'b0;
    last0 = 32'h0; last1 = 32'h0;
    mrd_pend = 1'b0;
    rq_v[0] = 1'b0; rq_v[1] = 1'b0;
  endtask

  task automatic arm(input int p, input logic [3:0] we, input logic [31:0] a, input logic [31:0] d);
    rq_v[p] = 1'b1; rq_we[p] = we; rq_addr[p] = a; rq_wdata[p] = d;
  endtask

  // One clock cycle: drive at posedge+1, check and advance the model at negedge
  task automatic cycle();
    int s, s1, s2, win;
    logic req1;
    logic [3:0] idx;
    @(posedge clk); #1;
    if (mrd_pend) m_rdata = mem[mrd_idx];
    mrd_pend = 1'b0;
    p0_req = rq_v[0]; p0_we = rq_we[0]; p0_addr = rq_addr[0]; p0_wdata = rq_wdata[0];
    p1_req = rq_v[1]; p1_we = rq_we[1]; p1_addr = rq_addr[1]; p1_wdata = rq_wdata[1];
    @(negedge clk);
    s = cyc % 8;
    req1 = rq_v[1];
    win = -1;
    if (busy == 0 && (rq_v[0] || rq_v[1])) begin
      if (rq_v[0] && rq_v[1]) begin
`ifdef DMEM_ARB_RR_EN
        win = prefer_ldr ? 1 : 0;
`else
        win = (starve == STARVE_MAX) ? 1 : 0;
`endif
      end else begin
        win = rq_v[1] ? 1 : 0;
      end
    end
    chk("p0_gnt", p0_gnt, win == 0);
    chk("p1_gnt", p1_gnt, win == 1);
    if (p0_gnt || p1_gnt) dut_grants.push_back(p1_gnt ? 1 : 0);
    chk("m_rd", m_rd, e_rd[s]);
    chk("m_we", m_we, e_we[s]);
    if (e_cv[s]) begin
      chk("m_addr", m_addr, e_addr[s]);
      if (e_we[s] != 4'h0) chk("m_wdata", m_wdata, e_wdata[s]);
    end
    chk("p0_rvalid", p0_rvalid, e_rv0[s]);
    chk("p1_rvalid", p1_rvalid, e_rv1[s]);
    if (e_rv0[s]) last0 = e_rvd[s];
    if (e_rv1[s]) last1 = e_rvd[s];
    chk("p0_rdata", p0_rdata, last0);
    chk("p1_rdata", p1_rdata, last1);
    e_cv[s] = 1'b0; e_we[s] = 4'h0; e_rd[s] = 1'b0; e_rv0[s] = 1'b0; e_rv1[s] = 1'b0;
    // Bench memory reacts to whatever command the DUT put out
    if (m_rd) begin mrd_pend = 1'b1; mrd_idx = m_addr[5:2]; end
    for (int b = 0; b < 4; b++)
      if (m_we[b]) mem[m_addr[5:2]][8*b +: 8] = m_wdata[8*b +: 8];
    // Schedule the consequences of this cycle's grant
    if (win >= 0) begin
      s1 = (cyc + 1) % 8; s2 = (cyc + 2) % 8;
      idx = rq_addr[win][5:2];
      e_cv[s1] = 1'b1; e_addr[s1] = rq_addr[win]; e_we[s1] = rq_we[win];
      e_wdata[s1] = rq_wdata[win]; e_rd[s1] = (rq_we[win] == 4'h0);
      if (rq_we[win] == 4'h0) begin
        if (win == 0) e_rv0[s2] = 1'b1; else e_rv1[s2] = 1'b1;
        e_rvd[s2] = ref_mem[idx];
        busy = 2;
      end else begin
        for (int b = 0; b < 4; b++)
          if (rq_we[win][b]) ref_mem[idx][8*b +: 8] = rq_wdata[win][8*b +: 8];
        busy = 1;
      end
      prefer_ldr = (win == 0);
      rq_v[win] = 1'b0;
    end else if (busy > 0) begin
      busy--;
    end
    if (!req1) starve = 0;
    else if (win == 1) starve = 0;
    else if (win == 0 && starve < STARVE_MAX) starve++;
    cyc++;
  endtask

  initial begin
    rst_n = 1'b0;
    p0_req = 1'b0; p0_we = 4'h0; p0_addr = 32'h0; p0_wdata = 32'h0;
    p1_req = 1'b0; p1_we = 4'h0; p1_addr = 32'h0; p1_wdata = 32'h0;
    m_rdata = 32'h0;
    cyc = 0;
    for (int i = 0; i < 2; i++) begin rq_we[i] = 4'h0; rq_addr[i] = 32'h0; rq_wdata[i] = 32'h0; end
    for (int i = 0; i < 16; i++) begin
      mem[i] = 32'h1000_0000 + i * 32'h0000_0101;
      ref_mem[i] = mem[i];
    end
    mem[4] = 32'hDEAD_BEEF; ref_mem[4] = 32'hDEAD_BEEF;
    model_reset();

    // Reset state
    #12;
    chk("rst_gnt", {p0_gnt, p1_gnt}, 2'b00);
    chk("rst_rvalid", {p0_rvalid, p1_rvalid}, 2'b00);
    chk("rst_m_rd", m_rd, 1'b0);
    chk("rst_m_we", m_we, 4'h0);
    chk("rst_m_addr", m_addr, 32'h0);
    chk("rst_m_wdata", m_wdata, 32'h0);
    chk("rst_rdata", {p0_rdata, p1_rdata}, 64'h0);
    #1 rst_n = 1'b1;

    // p0 read of 0x10 returning 0xDEADBEEF
    arm(0, 4'h0, 32'h10, 32'h0);
    for (int i = 0; i < 4; i++) cycle();
    chk("p0_read_data", p0_rdata, 32'hDEAD_BEEF);

    // p1 byte write of 0xAA to 0x21
    arm(1, 4'b0001, 32'h21, 32'h0000_00AA);
    for (int i = 0; i < 3; i++) cycle();

    // Both ports requesting continuously
    dut_grants.delete();
    arm(0, 4'hF, 32'h30, 32'h1111_0000);
    arm(1, 4'hF, 32'h34, 32'h2222_0000);
    for (int i = 0; i < 24; i++) begin
      cycle();
      if (!rq_v[0]) arm(0, 4'hF, 32'h30, 32'h1111_0000 + i);
      if (!rq_v[1]) arm(1, 4'hF, 32'h34, 32'h2222_0000 + i);
    end
    chk("contend_grant_cnt", dut_grants.size() >= 10, 1'b1);
    for (int i = 0; i < 10 && i < dut_grants.size(); i++) begin
`ifdef DMEM_ARB_RR_EN
      chk("rr_order", dut_grants[i], i % 2);
`else
      chk("starve_order", dut_grants[i], (i % 5 == 4) ? 1 : 0);
`endif
    end
    rq_v[0] = 1'b0; rq_v[1] = 1'b0;
    for (int i = 0; i < 3; i++) cycle();

    // p0 request raised for one cycle during ISSUE only
    arm(1, 4'hF, 32'h08, 32'hCAFE_F00D);
    cycle();
    arm(0, 4'h0, 32'h0C, 32'h0);
    cycle();
    rq_v[0] = 1'b0;
    for (int i = 0; i < 3; i++) cycle();

    // Reset pulled in the RDWAIT cycle of a p0 read
    arm(0, 4'h0, 32'h10, 32'h0);
    cycle();
    cycle();
    @(posedge clk); #1;
    if (mrd_pend) m_rdata = mem[mrd_idx];
    mrd_pend = 1'b0;
    p0_req = 1'b0; p1_req = 1'b0;
    #1 chk("rdwait_rvalid", p0_rvalid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midrst_rvalid", {p0_rvalid, p1_rvalid}, 2'b00);
    chk("midrst_rdata", {p0_rdata, p1_rdata}, 64'h0);
    chk("midrst_m_rd", m_rd, 1'b0);
    chk("midrst_m_we", m_we, 4'h0);
    chk("midrst_m_addr", m_addr, 32'h0);
    chk("midrst_m_wdata", m_wdata, 32'h0);
    model_reset();
    @(posedge clk); #3 rst_n = 1'b1;
    arm(0, 4'h0, 32'h14, 32'h0);
    arm(1, 4'h0, 32'h18, 32'h0);
    for (int i = 0; i < 8; i++) cycle();

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      for (int p = 0; p < 2; p++) begin
        if (!rq_v[p]) begin
          if ($urandom_range(0, 99) < ((p == 1) ? 60 : 45))
            arm(p, ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0,
                32'($urandom_range(0, 63)), $urandom());
        end else if ($urandom_range(0, 99) < 4) begin
          rq_v[p] = 1'b0;
        end
      end
      cycle();
    end
    rq_v[0] = 1'b0; rq_v[1] = 1'b0;
    for (int i = 0; i < 4; i++) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
